// File: rtl/cpu_types_pkg.sv
// Shared CPU types plus the branch-target-buffer entry format and counter helpers.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int BTB_ENTRIES = 16;
    localparam int BTB_IDX_W   = $clog2(BTB_ENTRIES);
    localparam int BTB_TAG_W   = 32 - BTB_IDX_W - 2;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bpctr_t;

    // Tag field is sized for the default entry count.
    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        word_t                target;
        bpctr_t               ctr;
    } btb_entry_t;

    function automatic bpctr_t sat_inc(input bpctr_t c);
        return (c == STRONG_T) ? STRONG_T : bpctr_t'(c + 2'd1);
    endfunction

    function automatic bpctr_t sat_dec(input bpctr_t c);
        return (c == STRONG_NT) ? STRONG_NT : bpctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational fetch-side lookup,
// registered resolve-side update, and a running mispredict counter.
module branch_target_buffer
    import cpu_types_pkg::*;
#(
    parameter int ENTRIES = BTB_ENTRIES
) (
    input  logic  CLK,
    input  logic  nRST,
    input  word_t fetch_pc,
    output logic  pred_taken,
    output word_t pred_next,
    input  logic  upd_en,
    input  word_t upd_pc,
    input  logic  upd_taken,
    input  word_t upd_target,
    input  logic  upd_mispredict,
    output word_t mispredict_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    generate
        if (TAG_W != BTB_TAG_W) begin : g_bad_size
            $error("btb_entry_t tag width does not match ENTRIES");
        end
    endgenerate

    btb_entry_t r_btb [ENTRIES];
    word_t      r_mispredict_cnt;

    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_f_hit;
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_u_hit;

    assign w_f_idx = fetch_pc[IDX_W+1:2];
    assign w_f_tag = fetch_pc[31:IDX_W+2];
    assign w_u_idx = upd_pc[IDX_W+1:2];
    assign w_u_tag = upd_pc[31:IDX_W+2];
    assign w_u_hit = r_btb[w_u_idx].valid && (r_btb[w_u_idx].tag == w_u_tag);

    // Lookup reads the array directly, so a same-cycle update is seen only next cycle.
    always_comb begin
        w_f_hit    = r_btb[w_f_idx].valid && (r_btb[w_f_idx].tag == w_f_tag);
        pred_taken = w_f_hit && r_btb[w_f_idx].ctr[1];
        pred_next  = pred_taken ? r_btb[w_f_idx].target : fetch_pc + 32'd4;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};
            end
            r_mispredict_cnt <= '0;
        end else if (upd_en) begin
            if (w_u_hit) begin
                if (upd_taken) begin
                    r_btb[w_u_idx].ctr    <= sat_inc(r_btb[w_u_idx].ctr);
                    r_btb[w_u_idx].target <= upd_target;
                end else begin
                    r_btb[w_u_idx].ctr <= sat_dec(r_btb[w_u_idx].ctr);
                end
            end else if (upd_taken) begin
                r_btb[w_u_idx] <= '{valid: 1'b1, tag: w_u_tag, target: upd_target, ctr: WEAK_T};
            end
            if (upd_mispredict) begin
                r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
            end
        end
    end

    assign mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed-vector bench for branch_target_buffer with hand-computed expectations.
module tb_branch_target_buffer;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST;
    word_t fetch_pc;
    logic  pred_taken;
    word_t pred_next;
    logic  upd_en;
    word_t upd_pc;
    logic  upd_taken;
    word_t upd_target;
    logic  upd_mispredict;
    word_t mispredict_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    branch_target_buffer dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .fetch_pc       (fetch_pc),
        .pred_taken     (pred_taken),
        .pred_next      (pred_next),
        .upd_en         (upd_en),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Present one update at a negedge, let one rising edge consume it, then drop it.
    task automatic do_upd(input word_t pc, input logic tk, input word_t tgt, input logic mp);
        @(negedge CLK);
        upd_en = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_mispredict = mp;
        @(posedge CLK);
        #1 upd_en = 1'b0; upd_mispredict = 1'b0;
    endtask

    task automatic look(input string tag, input word_t pc, input logic tk, input word_t nxt);
        fetch_pc = pc;
        #1;
        chk({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, tk});
        chk({tag, ".next"}, pred_next, nxt);
    endtask

    initial begin
        nRST = 1'b0; fetch_pc = 32'h100;
        upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;

        // Reset state
        look("rst", 32'h100, 1'b0, 32'h104);
        chk("rst.cnt", mispredict_cnt, 32'd0);
        look("wrap4", 32'hFFFF_FFFC, 1'b0, 32'h0);
        @(negedge CLK); nRST = 1'b1;

        // Allocate on taken miss
        do_upd(32'h100, 1'b1, 32'h040, 1'b1);
        look("alloc", 32'h100, 1'b1, 32'h040);
        chk("alloc.cnt", mispredict_cnt, 32'd1);
        look("lowbits", 32'h102, 1'b1, 32'h040);

        // Decrement 10->01->00, then saturate up at 11
        do_upd(32'h100, 1'b0, 32'h999, 1'b0);
        look("dec1", 32'h100, 1'b0, 32'h104);
        do_upd(32'h100, 1'b0, 32'h999, 1'b0);
        look("dec2", 32'h100, 1'b0, 32'h104);
        do_upd(32'h100, 1'b1, 32'h080, 1'b0);
        look("inc1", 32'h100, 1'b0, 32'h104);
        do_upd(32'h100, 1'b1, 32'h080, 1'b0);
        look("inc2", 32'h100, 1'b1, 32'h080);
        do_upd(32'h100, 1'b1, 32'h088, 1'b0);
        do_upd(32'h100, 1'b1, 32'h088, 1'b0);
        do_upd(32'h100, 1'b0, 32'h999, 1'b0);
        look("sat", 32'h100, 1'b1, 32'h088);
        do_upd(32'h100, 1'b0, 32'h999, 1'b0);
        look("sat_dn", 32'h100, 1'b0, 32'h104);

        // upd_en low: everything ignored
        @(negedge CLK);
        upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h777; upd_mispredict = 1'b1;
        @(negedge CLK); upd_mispredict = 1'b0;
        look("noen", 32'h100, 1'b0, 32'h104);
        chk("noen.cnt", mispredict_cnt, 32'd1);

        // Conflict eviction at idx 0
        do_upd(32'h100, 1'b1, 32'h200, 1'b0);
        look("retrain", 32'h100, 1'b1, 32'h200);
        do_upd(32'h140, 1'b1, 32'h300, 1'b0);
        look("evict_old", 32'h100, 1'b0, 32'h104);
        look("evict_new", 32'h140, 1'b1, 32'h300);
        do_upd(32'h100, 1'b0, 32'h999, 1'b0);
        look("nt_miss", 32'h140, 1'b1, 32'h300);

        // Same-cycle lookup and update: old state now, new state next cycle
        @(negedge CLK);
        fetch_pc = 32'h140;
        upd_en = 1'b1; upd_pc = 32'h140; upd_taken = 1'b0; upd_mispredict = 1'b0;
        #1 chk("same.old", {31'd0, pred_taken}, 32'd1);
        @(posedge CLK);
        #1 upd_en = 1'b0;
        look("same.new", 32'h140, 1'b0, 32'h144);

        // Counter wrap
        @(negedge CLK);
        force dut.r_mispredict_cnt = 32'hFFFF_FFFF;
        #1 release dut.r_mispredict_cnt;
        do_upd(32'h180, 1'b0, 32'h0, 1'b1);
        chk("cnt.wrap", mispredict_cnt, 32'd0);

        // Asynchronous reset mid-cycle after training
        do_upd(32'h140, 1'b1, 32'h300, 1'b1);
        look("pre_rst", 32'h140, 1'b1, 32'h300);
        @(negedge CLK);
        #2 nRST = 1'b0;
        #1;
        chk("arst.taken", {31'd0, pred_taken}, 32'd0);
        chk("arst.next", pred_next, 32'h144);
        chk("arst.cnt", mispredict_cnt, 32'd0);

        // Update presented as reset releases is applied on the first edge
        @(negedge CLK);
        nRST = 1'b1;
        upd_en = 1'b1; upd_pc = 32'h1C4; upd_taken = 1'b1; upd_target = 32'h500; upd_mispredict = 1'b1;
        @(posedge CLK);
        #1 upd_en = 1'b0; upd_mispredict = 1'b0;
        look("post.140", 32'h140, 1'b0, 32'h144);
        look("post.100", 32'h100, 1'b0, 32'h104);
        look("post.1c4", 32'h1C4, 1'b1, 32'h500);
        chk("post.cnt", mispredict_cnt, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
